// File: rtl/bitwrite_rr_scheduler.sv
// Round-robin arbiter sharing the single-port bit-RAM write channel among NUM_CORES cores.
// One grant per clock, registered RAM write and a one-cycle ACK back to the winning core.
module bitwrite_rr_scheduler #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16,
  parameter int PTR_W     = 2
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_CORES-1:0]        i_core_req,
  input  logic [NUM_CORES-1:0]        i_core_write_data,
  input  logic [NUM_CORES*ADDR_W-1:0] i_core_write_addr,
  input  logic                        i_ram_hold,
  output logic                        o_ram_we,
  output logic                        o_ram_write_data,
  output logic [ADDR_W-1:0]           o_ram_write_addr,
  output logic [NUM_CORES-1:0]        o_core_ack,
  output logic [15:0]                 o_grant_cnt,
  output logic                        o_busy
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_STALL} state_t;

  state_t               r_state;
  logic [PTR_W-1:0]     r_ptr;
  logic [NUM_CORES-1:0] r_mask;

  logic [NUM_CORES-1:0] w_elig;
  logic                 w_any;
  logic                 w_found;
  logic                 w_grant;
  logic [PTR_W-1:0]     w_gnt_idx;
  logic [PTR_W-1:0]     w_ptr_nxt;
  logic [NUM_CORES-1:0] w_gnt_onehot;
  int                   w_idx;

  // The mask hides the still-high request of the core whose ACK is in flight.
  assign w_elig  = i_core_req & ~r_mask;
  assign w_any   = |w_elig;
  assign o_busy  = w_any;
  assign w_grant = w_found & ~i_ram_hold;

  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_idx     = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NUM_CORES) w_idx = w_idx - NUM_CORES;
      if (!w_found && w_elig[w_idx]) begin
        w_found   = 1'b1;
        w_gnt_idx = PTR_W'(w_idx);
      end
    end
  end

  assign w_ptr_nxt    = (w_gnt_idx == PTR_W'(NUM_CORES - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
  assign w_gnt_onehot = NUM_CORES'(1) << w_gnt_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= S_IDLE;
      r_ptr            <= '0;
      r_mask           <= '0;
      o_ram_we         <= 1'b0;
      o_ram_write_data <= 1'b0;
      o_ram_write_addr <= '0;
      o_core_ack       <= '0;
      o_grant_cnt      <= '0;
    end else begin
      o_ram_we   <= w_grant;
      o_core_ack <= '0;
      r_mask     <= '0;
      if (w_grant) begin
        o_ram_write_addr <= i_core_write_addr[int'(w_gnt_idx)*ADDR_W +: ADDR_W];
        o_ram_write_data <= i_core_write_data[w_gnt_idx];
        o_core_ack       <= w_gnt_onehot;
        r_mask           <= w_gnt_onehot;
        r_ptr            <= w_ptr_nxt;
        o_grant_cnt      <= o_grant_cnt + 16'd1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_any) r_state <= i_ram_hold ? S_STALL : S_GRANT;
        end
        S_GRANT: begin
          if (i_ram_hold)  r_state <= S_STALL;
          else if (!w_any) r_state <= S_IDLE;
        end
        S_STALL: begin
          if (!i_ram_hold) r_state <= w_any ? S_GRANT : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwrite_rr_scheduler.sv
// Bench for bitwrite_rr_scheduler: directed vector table, counter wrap, and randomized
// traffic against a queue-free round-robin reference model.
module tb_bitwrite_rr_scheduler;
  localparam int N  = 4;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N-1:0]  wdata;
  logic [N*AW-1:0] waddr;
  logic          hold;
  logic          ram_we;
  logic          ram_wdata;
  logic [AW-1:0] ram_waddr;
  logic [N-1:0]  ack;
  logic [15:0]   gcnt;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bitwrite_rr_scheduler #(.NUM_CORES(N), .ADDR_W(AW), .PTR_W(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_core_req(req), .i_core_write_data(wdata),
    .i_core_write_addr(waddr), .i_ram_hold(hold), .o_ram_we(ram_we),
    .o_ram_write_data(ram_wdata), .o_ram_write_addr(ram_waddr), .o_core_ack(ack),
    .o_grant_cnt(gcnt), .o_busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        hold;
    logic        busy;
    logic        we;
    logic [3:0]  ack;
    logic [15:0] cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic h,
                              input logic b, input logic w, input logic [3:0] a,
                              input logic [15:0] c);
    vec_t v;
    v.rst = r; v.req = q; v.hold = h; v.busy = b; v.we = w; v.ack = a; v.cnt = c;
    return v;
  endfunction

  vec_t tbl[26];

  // Random-phase environment and reference model state
  int          m_ptr;
  logic [N-1:0] m_mask;
  int          m_cnt;
  logic [AW-1:0] m_addr;
  logic        m_data;
  logic        pend[N];
  logic [AW-1:0] caddr[N];
  logic        cdata[N];
  int          wait_cnt[N];

  initial begin
    rst = 1'b1; req = '0; hold = 1'b0;
    wdata = 4'b0110;
    waddr = {16'h0013, 16'h0012, 16'h0011, 16'h0010};

    //           rst   req     hold  busy  we    ack      cnt
    tbl[0]  = mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd0);
    tbl[1]  = mk(1'b0, 4'b0100, 1'b0, 1'b1, 1'b1, 4'b0100, 16'd1);   // T1
    tbl[2]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1);
    tbl[3]  = mk(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd0);
    tbl[4]  = mk(1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 4'b0001, 16'd1);   // T2
    tbl[5]  = mk(1'b0, 4'b1110, 1'b0, 1'b1, 1'b1, 4'b0010, 16'd2);
    tbl[6]  = mk(1'b0, 4'b1100, 1'b0, 1'b1, 1'b1, 4'b0100, 16'd3);
    tbl[7]  = mk(1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 4'b1000, 16'd4);
    tbl[8]  = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd4);
    tbl[9]  = mk(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, 4'b0001, 16'd5);   // T3
    tbl[10] = mk(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, 4'b1000, 16'd6);
    tbl[11] = mk(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, 4'b0001, 16'd7);
    tbl[12] = mk(1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, 4'b1000, 16'd8);
    tbl[13] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd8);
    tbl[14] = mk(1'b0, 4'b1111, 1'b0, 1'b1, 1'b1, 4'b0001, 16'd9);   // T4
    tbl[15] = mk(1'b0, 4'b1110, 1'b1, 1'b1, 1'b0, 4'b0000, 16'd9);
    tbl[16] = mk(1'b0, 4'b1110, 1'b1, 1'b1, 1'b0, 4'b0000, 16'd9);
    tbl[17] = mk(1'b0, 4'b1110, 1'b1, 1'b1, 1'b0, 4'b0000, 16'd9);
    tbl[18] = mk(1'b0, 4'b1110, 1'b0, 1'b1, 1'b1, 4'b0010, 16'd10);
    tbl[19] = mk(1'b0, 4'b1100, 1'b0, 1'b1, 1'b1, 4'b0100, 16'd11);
    tbl[20] = mk(1'b0, 4'b1000, 1'b0, 1'b1, 1'b1, 4'b1000, 16'd12);
    tbl[21] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd12);
    tbl[22] = mk(1'b0, 4'b0011, 1'b0, 1'b1, 1'b1, 4'b0001, 16'd13);  // T5
    tbl[23] = mk(1'b1, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b0000, 16'd0);
    tbl[24] = mk(1'b0, 4'b1010, 1'b0, 1'b1, 1'b1, 4'b0010, 16'd1);
    tbl[25] = mk(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 16'd1);

    for (int r = 0; r < 26; r++) begin
      rst = tbl[r].rst; req = tbl[r].req; hold = tbl[r].hold;
      #1;
      chk($sformatf("row%0d_busy", r), 32'(busy), 32'(tbl[r].busy));
      tick();
      chk($sformatf("row%0d_we", r), 32'(ram_we), 32'(tbl[r].we));
      chk($sformatf("row%0d_ack", r), 32'(ack), 32'(tbl[r].ack));
      chk($sformatf("row%0d_cnt", r), 32'(gcnt), 32'(tbl[r].cnt));
      if (tbl[r].ack != 4'b0000) begin
        for (int g = 0; g < N; g++) begin
          if (tbl[r].ack[g]) begin
            chk($sformatf("row%0d_addr", r), 32'(ram_waddr), 32'(16'h0010 + 16'(g)));
            chk($sformatf("row%0d_data", r), 32'(ram_wdata), 32'(wdata[g]));
          end
        end
      end
    end

    // T6: counter wrap after 0xFFFF grants of sustained alternating traffic
    rst = 1'b1; req = '0; hold = 1'b0;
    tick();
    rst = 1'b0; req = 4'b1001;
    repeat (65535) @(posedge clk);
    #1;
    chk("wrap_pre_cnt", 32'(gcnt), 32'h0000FFFF);
    tick();
    chk("wrap_cnt", 32'(gcnt), 32'h00000000);
    chk("wrap_we", 32'(ram_we), 32'd1);
    req = '0;
    tick();

    // Randomized traffic with hold and occasional reset against the reference model
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_ptr = 0; m_mask = '0; m_cnt = 0; m_addr = '0; m_data = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0; caddr[i] = '0; cdata[i] = 1'b0; wait_cnt[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] elig;
      logic [N-1:0] exp_ack;
      logic         exp_we;
      int           g;
      for (int i = 0; i < N; i++) begin
        req[i] = pend[i];
        wdata[i] = cdata[i];
        waddr[i*AW +: AW] = caddr[i];
      end
      hold = ($urandom_range(0, 4) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      #1;
      elig = req & ~m_mask;
      chk("rnd_busy", 32'(busy), 32'(|elig));
      g = -1;
      if (!hold) begin
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (m_ptr + k) % N;
          if (g < 0 && elig[idx]) g = idx;
        end
      end
      tick();
      exp_ack = '0;
      exp_we  = 1'b0;
      if (rst) begin
        m_ptr = 0; m_mask = '0; m_cnt = 0; m_addr = '0; m_data = 1'b0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      end else if (g >= 0) begin
        exp_we  = 1'b1;
        exp_ack = N'(1) << g;
        m_addr  = caddr[g];
        m_data  = cdata[g];
        m_mask  = exp_ack;
        m_ptr   = (g + 1) % N;
        m_cnt   = (m_cnt + 1) % 65536;
        for (int j = 0; j < N; j++) if (elig[j] && j != g) wait_cnt[j]++;
        chk("rnd_fair", 32'(wait_cnt[g] < N), 32'd1);
        wait_cnt[g] = 0;
      end else begin
        m_mask = '0;
      end
      chk("rnd_we", 32'(ram_we), 32'(exp_we));
      chk("rnd_ack", 32'(ack), 32'(exp_ack));
      chk("rnd_cnt", 32'(gcnt), 32'(m_cnt));
      chk("rnd_addr", 32'(ram_waddr), 32'(m_addr));
      chk("rnd_data", 32'(ram_wdata), 32'(m_data));
      for (int i = 0; i < N; i++) begin
        if (exp_ack[i]) begin
          pend[i] = ($urandom_range(0, 1) == 1);
          caddr[i] = AW'($urandom_range(0, 65535));
          cdata[i] = 1'($urandom_range(0, 1));
        end else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          caddr[i] = AW'($urandom_range(0, 65535));
          cdata[i] = 1'($urandom_range(0, 1));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
